// File: rtl/lsu_pkg.sv
// Shared types for the load/store splitter: access sizes, FSM states
// and the size-to-byte-mask helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_WAIT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic [3:0] size_mask(size_e sz);
        case (sz)
            SZ_B, SZ_BU: return 4'b0001;
            SZ_H, SZ_HU: return 4'b0011;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: enables and store shift over a two-word window,
// plus load extraction and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rd0,
    input  logic [31:0] rd1,
    output logic [7:0]  bem,
    output logic [63:0] wd64,
    output logic [31:0] rdata
);

    logic [63:0] rd64;
    logic [31:0] r;

    always_comb begin
        bem   = {4'b0000, size_mask(size)} << off;
        wd64  = {32'h0, wdata} << {off, 3'b000};
        rd64  = {rd1, rd0} >> {off, 3'b000};
        r     = rd64[31:0];
        rdata = r;
        case (size)
            SZ_B:    rdata = {{24{r[7]}}, r[7:0]};
            SZ_H:    rdata = {{16{r[15]}}, r[15:0]};
            SZ_BU:   rdata = {24'h0, r[7:0]};
            SZ_HU:   rdata = {16'h0, r[15:0]};
            default: rdata = r;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// Load/store initiator: one or two aligned word beats per core access,
// with load reassembly and extension.
module lsu_split
    import lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1,
    parameter int AW               = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e        state, nxt;
    logic          we_q, err_q;
    size_e         size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q, rd0, rd1;

    logic          idle, accept, split, illegal;
    size_e         a_size;
    logic [1:0]    a_off;
    logic [31:0]   a_wdata, ext;
    logic [7:0]    bem;
    logic [63:0]   wd64;
    logic [AW-1:0] addr0, addr1;

    assign idle   = (state == S_IDLE);
    assign accept = req_valid & req_ready;

    // In IDLE the aligner decodes the incoming request; afterwards it
    // works from the registered copy, so one instance serves both.
    assign a_size  = idle ? size_e'(req_size) : size_q;
    assign a_off   = idle ? req_addr[1:0] : addr_q[1:0];
    assign a_wdata = idle ? req_wdata : wdata_q;

    lsu_align u_align (
        .size  (a_size),
        .off   (a_off),
        .wdata (a_wdata),
        .rd0   (rd0),
        .rd1   (rd1),
        .bem   (bem),
        .wd64  (wd64),
        .rdata (ext)
    );

    assign split   = |bem[7:4];
    assign illegal = (req_size == 3'b011)
                   | (req_size[2:1] == 2'b11)
                   | (req_we & req_size[2])
                   | (split & (ALLOW_MISALIGNED == 0));

    assign addr0 = {addr_q[AW-1:2], 2'b00};
    assign addr1 = addr0 + AW'(4);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (accept) nxt = illegal ? S_DONE : S_BEAT0;
            S_BEAT0: if (mem_ready)
                         nxt = !we_q ? S_WAIT0
                             : (split ? S_BEAT1 : S_DONE);
            S_WAIT0: nxt = split ? S_BEAT1 : S_DONE;
            S_BEAT1: if (mem_ready) nxt = we_q ? S_DONE : S_WAIT1;
            S_WAIT1: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0     <= '0;
            rd1     <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= illegal;
                size_q  <= size_e'(req_size);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_WAIT0) rd0 <= mem_rdata;
            if (state == S_WAIT1) rd1 <= mem_rdata;
        end
    end

    assign req_ready = idle & ~reset;

    always_comb begin
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        unique case (state)
            S_BEAT0: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_be    = bem[3:0];
                mem_addr  = addr0;
                mem_wdata = wd64[31:0];
            end
            S_BEAT1: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_be    = bem[7:4];
                mem_addr  = addr1;
                mem_wdata = wd64[63:32];
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q | err_q) ? 32'h0 : ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: byte-array memory slave plus a byte-level
// reference model of the load/store semantics.
module tb_lsu_split;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_we;
    logic        mem_ready = 1'b1;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        rdy0, rv0, err0, mv0, mwe0;
    logic [31:0] rdata0, maddr0, mwd0;
    logic [3:0]  mbe0;
    logic        mem_ready0 = 1'b1;
    logic [31:0] mem_rdata0 = 32'h0;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int mv0_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } beat_t;
    beat_t beats[$];

    logic [7:0] mem [logic [31:0]];
    logic [7:0] rmem [logic [31:0]];

    lsu_split #(.ALLOW_MISALIGNED(1), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    lsu_split #(.ALLOW_MISALIGNED(0), .AW(32)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rdata0),
        .resp_err(err0),
        .mem_valid(mv0), .mem_ready(mem_ready0),
        .mem_we(mwe0), .mem_be(mbe0),
        .mem_addr(maddr0), .mem_wdata(mwd0),
        .mem_rdata(mem_rdata0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_mem(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic int nbytes(logic [2:0] sz);
        return (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    endfunction

    // Store into the reference; first_word_only models a write that
    // was cut short after its first beat.
    function automatic void ref_store(logic [31:0] a, logic [2:0] sz,
                                      logic [31:0] d, bit first_word_only);
        for (int i = 0; i < nbytes(sz); i++)
            if (!first_word_only || (int'(a[1:0]) + i) < 4)
                rmem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            v[8*i +: 8] = rd_ref(a + 32'(i));
        if (sz == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    always @(negedge clk) begin
        case (rdy_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 3) != 0);
            default: mem_ready = 1'b0;
        endcase
        if (mv0) mv0_cnt++;
    end

    always @(posedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            beats.push_back('{mem_addr, mem_be, mem_wdata, mem_we});
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= {rd_mem(mem_addr + 32'd3), rd_mem(mem_addr + 32'd2),
                              rd_mem(mem_addr + 32'd1), rd_mem(mem_addr)};
            end
        end
    end

    // Entered and left at a falling edge. wt counts falling edges spent
    // waiting for req_ready; lat counts edges from accept to resp_valid.
    task automatic do_req(input bit sel, input bit we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output int lat, output int wt);
        beats.delete();
        req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        if (sel) req_valid0 = 1'b1;
        else     req_valid  = 1'b1;
        wt = 0;
        while (!(sel ? rdy0 : req_ready) && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        if (wt >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout got req_ready=0 need 1");
        end
        @(posedge clk);
        #1 req_valid = 1'b0; req_valid0 = 1'b0;
        lat = 0; rd = 32'h0; err = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (sel ? rv0 : resp_valid) begin
                lat = k;
                rd  = sel ? rdata0 : resp_rdata;
                err = sel ? err0 : resp_err;
                break;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout got no resp_valid need pulse");
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b rv=%b mv=%b need 0 0 0",
                     req_ready, resp_valid, mem_valid);
        end
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata, resp_rdata, resp_err} !== '0) begin
            errors++;
            $display("FAIL reset_data got be=%b addr=%h wd=%h rd=%h need all 0",
                     mem_be, mem_addr, mem_wdata, resp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready got %b need 1", req_ready);
        end
    endtask

    task automatic test_aligned_word;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 1, 3'b010, 32'h40, 32'hDEADBEEF, rd, err, lat, wt);
        ref_store(32'h40, 3'b010, 32'hDEADBEEF, 0);
        checks++;
        if (beats.size() != 1 || beats[0].a !== 32'h40 || beats[0].be !== 4'b1111
            || beats[0].wd !== 32'hDEADBEEF || beats[0].we !== 1'b1) begin
            errors++;
            $display("FAIL sw_beat got n=%0d need 1 beat 40/1111/deadbeef",
                     beats.size());
        end
        checks++;
        if (lat != 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL sw_latency got %0d err=%b need 2 err=0", lat, err);
        end
        do_req(0, 0, 3'b010, 32'h40, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== 32'hDEADBEEF || lat != 3) begin
            errors++;
            $display("FAIL lw_aligned got %h lat %0d need deadbeef lat 3", rd, lat);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 1, 3'b000, 32'h43, 32'h000000A5, rd, err, lat, wt);
        ref_store(32'h43, 3'b000, 32'h000000A5, 0);
        checks++;
        if (beats.size() != 1 || beats[0].be !== 4'b1000
            || beats[0].wd[31:24] !== 8'hA5 || beats[0].a !== 32'h40) begin
            errors++;
            $display("FAIL sb_beat got n=%0d need be=1000 lane3=a5", beats.size());
        end
        do_req(0, 0, 3'b000, 32'h43, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== 32'hFFFFFFA5) begin
            errors++;
            $display("FAIL lb_sign got %h need ffffffa5", rd);
        end
        do_req(0, 0, 3'b100, 32'h43, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== 32'h000000A5) begin
            errors++;
            $display("FAIL lbu_zero got %h need 000000a5", rd);
        end
    endtask

    task automatic test_split;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 1, 3'b010, 32'h46, 32'h11223344, rd, err, lat, wt);
        ref_store(32'h46, 3'b010, 32'h11223344, 0);
        checks++;
        if (beats.size() != 2) begin
            errors++;
            $display("FAIL split_sw_count got %0d need 2", beats.size());
        end else begin
            checks++;
            if (beats[0].a !== 32'h44 || beats[0].be !== 4'b1100
                || beats[0].wd !== 32'h33440000) begin
                errors++;
                $display("FAIL split_beat0 got %h/%b/%h need 44/1100/33440000",
                         beats[0].a, beats[0].be, beats[0].wd);
            end
            checks++;
            if (beats[1].a !== 32'h48 || beats[1].be !== 4'b0011
                || beats[1].wd !== 32'h00001122) begin
                errors++;
                $display("FAIL split_beat1 got %h/%b/%h need 48/0011/00001122",
                         beats[1].a, beats[1].be, beats[1].wd);
            end
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL split_sw_latency got %0d need 3", lat);
        end
        do_req(0, 0, 3'b010, 32'h46, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== 32'h11223344 || lat != 5) begin
            errors++;
            $display("FAIL split_lw got %h lat %0d need 11223344 lat 5", rd, lat);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 1, 3'b000, 32'hFFFFFFFF, 32'h80, rd, err, lat, wt);
        ref_store(32'hFFFFFFFF, 3'b000, 32'h80, 0);
        do_req(0, 1, 3'b000, 32'h0, 32'h7F, rd, err, lat, wt);
        ref_store(32'h0, 3'b000, 32'h7F, 0);
        do_req(0, 0, 3'b001, 32'hFFFFFFFF, 32'h0, rd, err, lat, wt);
        checks++;
        if (beats.size() != 2 || beats[0].a !== 32'hFFFFFFFC
            || beats[1].a !== 32'h0) begin
            errors++;
            $display("FAIL wrap_beats got n=%0d need fffffffc then 00000000",
                     beats.size());
        end
        checks++;
        if (rd !== 32'h00007F80) begin
            errors++;
            $display("FAIL wrap_lh got %h need 00007f80", rd);
        end
        do_req(0, 0, 3'b101, 32'hFFFFFFFF, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== 32'h00007F80) begin
            errors++;
            $display("FAIL wrap_lhu got %h need 00007f80", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 0, 3'b111, 32'h40, 32'h0, rd, err, lat, wt);
        checks++;
        if (err !== 1'b1 || lat != 1 || beats.size() != 0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_size got err=%b lat=%0d n=%0d need 1/1/0",
                     err, lat, beats.size());
        end
        do_req(0, 1, 3'b100, 32'h40, 32'h0, rd, err, lat, wt);
        checks++;
        if (err !== 1'b1 || beats.size() != 0) begin
            errors++;
            $display("FAIL err_store_bu got err=%b n=%0d need 1/0",
                     err, beats.size());
        end
        mv0_cnt = 0;
        do_req(1, 1, 3'b001, 32'h3, 32'h1234, rd, err, lat, wt);
        checks++;
        if (err !== 1'b1 || lat != 1 || mv0_cnt != 0) begin
            errors++;
            $display("FAIL err_misaligned got err=%b lat=%0d mv=%0d need 1/1/0",
                     err, lat, mv0_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic err; int lat, wt;
        do_req(0, 0, 3'b010, 32'h40, 32'h0, rd, err, lat, wt);
        do_req(0, 0, 3'b001, 32'h46, 32'h0, rd, err, lat, wt);
        checks++;
        if (wt != 1 || rd !== ref_load(32'h46, 3'b001)) begin
            errors++;
            $display("FAIL b2b got wait=%0d rd=%h need 1 %h",
                     wt, rd, ref_load(32'h46, 3'b001));
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_pulse got rv=%b rdy=%b need 0 1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_stall_reset;
        logic [31:0] a0, w0; logic [3:0] b0;
        logic [31:0] rd; logic err; int lat, wt;
        bit moved = 0, seen = 0;
        beats.delete();
        req_we = 1; req_size = 3'b010; req_addr = 32'h4E; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rdy_mode = 2;
        @(negedge clk);
        a0 = mem_addr; b0 = mem_be; w0 = mem_wdata;
        checks++;
        if (mem_valid !== 1'b1 || a0 !== 32'h50 || b0 !== 4'b0011
            || w0 !== 32'h0000CAFE) begin
            errors++;
            $display("FAIL stall_beat1 got %b/%h/%b/%h need 1/50/0011/0000cafe",
                     mem_valid, a0, b0, w0);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || mem_addr !== a0 || mem_be !== b0
                || mem_wdata !== w0) moved = 1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL stall_stable got change need stable outputs");
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; rdy_mode = 0;
        ref_store(32'h4E, 3'b010, 32'hCAFEF00D, 1);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got mv=%b rdy=%b rv=%b need 0 1 0",
                     mem_valid, req_ready, resp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_resp got resp_valid need none");
        end
        do_req(0, 0, 3'b010, 32'h4C, 32'h0, rd, err, lat, wt);
        checks++;
        if (rd !== ref_load(32'h4C, 3'b010)) begin
            errors++;
            $display("FAIL beat0_kept got %h need %h", rd, ref_load(32'h4C, 3'b010));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, exp; logic err; int lat, wt, nb;
        logic [2:0] sz; bit we, bad;
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: sz = 3'b000;
                1: sz = 3'b001;
                2: sz = 3'b010;
                3: sz = 3'b100;
                4: sz = 3'b101;
                5: sz = 3'b010;
                default: sz = 3'($urandom_range(0, 7));
            endcase
            a = ($urandom_range(0, 1) != 0) ? 32'h100 + 32'($urandom_range(0, 15))
                                            : 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            d = $urandom;
            bad = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111)
                  || (we && sz[2]);
            nb = bad ? 0 : ((int'(a[1:0]) + nbytes(sz) > 4) ? 2 : 1);
            exp = (bad || we) ? 32'h0 : ref_load(a, sz);
            do_req(0, we, sz, a, d, rd, err, lat, wt);
            if (!bad && we) ref_store(a, sz, d, 0);
            checks++;
            if (err !== bad || rd !== exp || beats.size() != nb) begin
                errors++;
                $display("FAIL rand_%0d we=%b sz=%b a=%h got rd=%h err=%b n=%0d need %h %b %0d",
                         n, we, sz, a, rd, err, beats.size(), exp, bad, nb);
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_byte();
        test_split();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_stall_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Load/store initiator between the core datapath and the word-organised data memory.
- Accepts one byte, halfword or word access per handshake using the RISC-V funct3 size code.
- Turns each access into one aligned word beat, or two if the access crosses a word boundary. Each beat carries byte enables and pre-shifted write data.
- For loads, reassembles the returned words and sign- or zero-extends the result before returning it to the core.

Parameters:
- ALLOW_MISALIGNED, 1, when 1 word-crossing accesses are split into two beats; when 0 they complete with resp_err and no memory access.
- AW, 32, address width in bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal size, or misaligned access with ALLOW_MISALIGNED=0
- mem_valid  out  1  memory beat valid
- mem_ready  in  1  memory accepts beat
- mem_we  out  1  beat is a write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  AW  word-aligned beat address, [1:0]=00
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  read word, valid exactly 1 cycle after an accepted read beat

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- FSM states are IDLE, BEAT0, WAIT0, BEAT1, WAIT1, DONE.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready, and is registered at that edge.
- Decode at accept:
  - mask = 0001 (B/BU), 0011 (H/HU), 1111 (W).
  - off = addr[1:0].
  - bem[7:0] = mask << off.
  - split = |bem[7:4].
  - wd64 = {32'b0, wdata} << 8*off.
- Illegal request: size 011, 110 or 111; or BU/HU with we=1; or split with ALLOW_MISALIGNED=0. The FSM goes IDLE->DONE with resp_err=1 and issues no beat.
- BEAT0:
  - mem_valid=1, mem_addr={addr[AW-1:2],2'b00}, mem_be=bem[3:0], mem_wdata=wd64[31:0].
  - Hold all mem_* outputs stable until mem_ready.
  - On accept: a load goes to WAIT0; a store goes to BEAT1 if split, else DONE.
- WAIT0: capture mem_rdata into rd0, then go to BEAT1 if split, else DONE.
- BEAT1:
  - mem_addr = beat0 address + 4, wrapping 0xFFFF_FFFC -> 0x0000_0000.
  - mem_be=bem[7:4], mem_wdata=wd64[63:32].
  - On accept: a load goes to WAIT1, a store goes to DONE.
- WAIT1: capture rd1, then go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - Load data: r = ({rd1, rd0} >> 8*off)[31:0]. Sign-extend from bit 7 (B) or bit 15 (H); zero-extend for BU/HU; pass through for W.
  - Lanes outside bem never influence resp_rdata.
- mem_valid=0 in every state other than BEAT0 and BEAT1.
- mem_ready is ignored when mem_valid=0.
- Latency, accept edge to resp_valid:
  - aligned load: 3 cycles
  - aligned store: 2 cycles
  - split load: 5 cycles
  - split store: 3 cycles
  - each of the above is extended by any cycles of mem_ready stall
  - error response: 1 cycle
- Back-to-back: the next request can be accepted in the cycle after DONE.
- Reset mid-operation: all state returns to reset values at that edge. A completed BEAT0 write is not rolled back, and no response is produced.

Decomposition:
- lsu_pkg holds:
  - size_e enum (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101)
  - state_e enum for the six FSM states
  - function size_mask(size_e) returning the 4-bit mask
- Sub-module lsu_align (combinational) holds the byte-enable and write-data shift plus the load extract/extend. It is shared by the two-beat path and the single-beat path.

Test Plan:
- Aligned SW then LW to 0x40, data 0xDEADBEEF, mem_ready always 1 -> one beat each: be=1111, addr=0x40, wdata=0xDEADBEEF. LW returns 0xDEADBEEF 3 cycles after accept.
- SB 0xA5 to 0x43, then LB and LBU from 0x43 -> store beat be=1000, wdata[31:24]=0xA5. LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- Split SW 0x11223344 to 0x46 -> beat0 addr 0x44, be=1100, wdata=0x33440000. Beat1 addr 0x48, be=0011, wdata=0x00001122. LW from 0x46 returns 0x11223344 after 5 cycles.
- Split LH from 0xFFFFFFFF, with byte 0xFFFFFFFF=0x80 and byte 0x0=0x7F -> beat1 addr 0x00000000. Returns 0x00007F80; LHU returns the same.
- Illegal size 3'b111, and SH to 0x3 with ALLOW_MISALIGNED=0 -> resp_err=1 and resp_valid one cycle after accept. mem_valid never asserts.
- mem_ready held 0 for 4 cycles during BEAT1 of a split store, then reset asserted -> mem_* stable while stalled. After the reset edge: mem_valid=0, req_ready=1 the following cycle, no resp_valid.
